// File: rtl/osd_wr_arbiter_pkg.sv
// Shared configuration for the OSD write arbiter: parameter defaults,
// window FSM encoding and the pending-count saturation helper.
package osd_wr_arbiter_pkg;

    localparam int DW_DEFAULT          = 20;
    localparam int FIFO_DEPTH_DEFAULT  = 4;
    localparam int MAX_PER_WIN_DEFAULT = 64;
    localparam int PENDING_W           = 4;

    typedef enum logic [1:0] {
        ST_CLOSED    = 2'd0,
        ST_OPEN      = 2'd1,
        ST_EXHAUSTED = 2'd2
    } win_state_e;

    function automatic logic [PENDING_W-1:0] sat_pending(input logic [31:0] n);
        return (n > 32'd15) ? 4'hF : n[PENDING_W-1:0];
    endfunction

endpackage

// File: rtl/osd_wr_fifo.sv
// Per-requester write queue with a registered ready and a one-cycle flush.
// Exposes the next-cycle count so the parent can register pending/defer.
module osd_wr_fifo
    import osd_wr_arbiter_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          N64_CLK_i,
    input  logic          CTRL_nRST,
    input  logic          flush,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          ready,
    input  logic          pop,
    output logic          empty,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count_next
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A push racing a flush is dropped along with the queued words.
    assign do_push = push_valid && ready && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (!do_push && do_pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            count <= count_next;
            ready <= (count_next < DEPTH_C);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // NOTE: storage has no reset; an empty count makes stale contents unobservable.
    always_ff @(posedge N64_CLK_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/osd_wr_arbiter.sv
// Round-robin arbiter draining two requester queues into OSD RAM during
// vertical blanking, with a per-window write budget.
module osd_wr_arbiter
    import osd_wr_arbiter_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int MAX_PER_WIN = MAX_PER_WIN_DEFAULT
) (
    input  logic                 N64_CLK_i,
    input  logic                 CTRL_nRST,
    input  logic                 vblank_i,
    input  logic                 flush_i,
    input  logic                 req0_valid_i,
    input  logic [DW-1:0]        req0_data_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [DW-1:0]        req1_data_i,
    output logic                 req1_ready_o,
    output logic                 wr_en_o,
    output logic [DW-1:0]        wr_data_o,
    output logic                 wr_src_o,
    output logic [PENDING_W-1:0] pending_o,
    output logic                 defer_o
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  BUDGET_MAX = 8'(MAX_PER_WIN);

    win_state_e    state, state_next;
    logic          vblank_q;
    logic [7:0]    budget, budget_next;
    logic          last_src;
    logic          sel_src;
    logic          pop_any;
    logic          closing;
    logic          empty0, empty1;
    logic [DW-1:0] head0, head1;
    logic [CW-1:0] cnt0_next, cnt1_next;
    logic [31:0]   pending_sum;

    osd_wr_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .N64_CLK_i  (N64_CLK_i),
        .CTRL_nRST  (CTRL_nRST),
        .flush      (flush_i),
        .push_valid (req0_valid_i),
        .push_data  (req0_data_i),
        .ready      (req0_ready_o),
        .pop        (pop_any && !sel_src),
        .empty      (empty0),
        .head       (head0),
        .count_next (cnt0_next)
    );

    osd_wr_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .N64_CLK_i  (N64_CLK_i),
        .CTRL_nRST  (CTRL_nRST),
        .flush      (flush_i),
        .push_valid (req1_valid_i),
        .push_data  (req1_data_i),
        .ready      (req1_ready_o),
        .pop        (pop_any && sel_src),
        .empty      (empty1),
        .head       (head1),
        .count_next (cnt1_next)
    );

    assign pending_sum = 32'(cnt0_next) + 32'(cnt1_next);

    always_comb begin
        state_next  = state;
        budget_next = budget;
        pop_any     = 1'b0;
        closing     = 1'b0;
        sel_src     = last_src;

        if (!empty0 && !empty1)
            sel_src = ~last_src;
        else if (!empty0)
            sel_src = 1'b0;
        else if (!empty1)
            sel_src = 1'b1;

        unique case (state)
            ST_CLOSED: begin
                // Only a fresh edge opens a window; a level already high at reset is ignored.
                if (vblank_i && !vblank_q) begin
                    state_next  = ST_OPEN;
                    budget_next = '0;
                end
            end
            ST_OPEN: begin
                if (!vblank_i) begin
                    state_next = ST_CLOSED;
                    closing    = 1'b1;
                end else if (!flush_i && (!empty0 || !empty1)) begin
                    pop_any     = 1'b1;
                    budget_next = budget + 8'd1;
                    if (budget_next >= BUDGET_MAX)
                        state_next = ST_EXHAUSTED;
                end
            end
            ST_EXHAUSTED: begin
                if (!vblank_i) begin
                    state_next = ST_CLOSED;
                    closing    = 1'b1;
                end
            end
            default: state_next = ST_CLOSED;
        endcase
    end

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state     <= ST_CLOSED;
            vblank_q  <= 1'b1;
            budget    <= '0;
            last_src  <= 1'b1;
            wr_en_o   <= 1'b0;
            wr_data_o <= '0;
            wr_src_o  <= 1'b0;
            pending_o <= '0;
            defer_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_next;
            vblank_q  <= vblank_i;
            budget    <= budget_next;
            wr_en_o   <= pop_any;
            pending_o <= sat_pending(pending_sum);
            defer_o   <= closing && (pending_sum != 32'd0);
            if (pop_any) begin
                last_src  <= sel_src;
                wr_src_o  <= sel_src;
                wr_data_o <= sel_src ? head1 : head0;
            end
        end
    end

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Directed bench for osd_wr_arbiter: one default instance and one with a
// write budget of two per window.
module tb_osd_wr_arbiter;
    import osd_wr_arbiter_pkg::*;

    localparam int DW = 20;

    logic clk = 1'b0;
    logic nrst;

    logic          a_vblank, a_flush, a_v0, a_v1, a_r0, a_r1;
    logic [DW-1:0] a_d0, a_d1, a_wr_data;
    logic          a_wr_en, a_wr_src, a_defer;
    logic [3:0]    a_pending;

    logic          b_vblank, b_flush, b_v0, b_v1, b_r0, b_r1;
    logic [DW-1:0] b_d0, b_d1, b_wr_data;
    logic          b_wr_en, b_wr_src, b_defer;
    logic [3:0]    b_pending;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    osd_wr_arbiter dut_a (
        .N64_CLK_i(clk), .CTRL_nRST(nrst), .vblank_i(a_vblank), .flush_i(a_flush),
        .req0_valid_i(a_v0), .req0_data_i(a_d0), .req0_ready_o(a_r0),
        .req1_valid_i(a_v1), .req1_data_i(a_d1), .req1_ready_o(a_r1),
        .wr_en_o(a_wr_en), .wr_data_o(a_wr_data), .wr_src_o(a_wr_src),
        .pending_o(a_pending), .defer_o(a_defer)
    );

    osd_wr_arbiter #(.MAX_PER_WIN(2)) dut_b (
        .N64_CLK_i(clk), .CTRL_nRST(nrst), .vblank_i(b_vblank), .flush_i(b_flush),
        .req0_valid_i(b_v0), .req0_data_i(b_d0), .req0_ready_o(b_r0),
        .req1_valid_i(b_v1), .req1_data_i(b_d1), .req1_ready_o(b_r1),
        .wr_en_o(b_wr_en), .wr_data_o(b_wr_data), .wr_src_o(b_wr_src),
        .pending_o(b_pending), .defer_o(b_defer)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int writes;

        nrst = 1'b0;
        {a_vblank, a_flush, a_v0, a_v1} = '0;
        {b_vblank, b_flush, b_v0, b_v1} = '0;
        a_d0 = '0; a_d1 = '0; b_d0 = '0; b_d1 = '0;

        // Reset state
        #12;
        check("rst_ready0", 32'(a_r0), 0);
        check("rst_ready1", 32'(a_r1), 0);
        check("rst_wr_en", 32'(a_wr_en), 0);
        check("rst_wr_data", 32'(a_wr_data), 0);
        check("rst_pending", 32'(a_pending), 0);
        check("rst_defer", 32'(a_defer), 0);
        check("rst_b_ready0", 32'(b_r0), 0);
        nrst = 1'b1;
        step();
        check("rel_ready0", 32'(a_r0), 1);
        check("rel_ready1", 32'(a_r1), 1);

        // Fill both queues, then try a fifth word on the full req0 queue
        for (int i = 0; i < 4; i++) begin
            a_v0 = 1'b1; a_d0 = 20'hA0000 + 20'(i);
            a_v1 = 1'b1; a_d1 = 20'hB0000 + 20'(i);
            step();
        end
        a_v0 = 1'b0; a_v1 = 1'b0;
        check("full_pending", 32'(a_pending), 8);
        check("full_ready0", 32'(a_r0), 0);
        check("full_ready1", 32'(a_r1), 0);
        a_v0 = 1'b1; a_d0 = 20'hAFFFF;
        step();
        a_v0 = 1'b0;
        check("over_pending", 32'(a_pending), 8);
        check("over_ready0", 32'(a_r0), 0);

        // Round-robin drain of 4+4
        a_vblank = 1'b1;
        step();
        check("rr_open_no_wr", 32'(a_wr_en), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_wr_en", 32'(a_wr_en), 1);
            check("rr_src", 32'(a_wr_src), 32'(i % 2));
            check("rr_data", 32'(a_wr_data),
                  (i % 2 == 0) ? 32'h000A0000 + 32'(i / 2) : 32'h000B0000 + 32'(i / 2));
            check("rr_pending", 32'(a_pending), 32'(7 - i));
        end
        step();
        check("rr_idle", 32'(a_wr_en), 0);
        a_vblank = 1'b0;
        step();
        check("rr_close_defer", 32'(a_defer), 0);

        // Three words on req0, written back-to-back after the window opens
        for (int i = 0; i < 3; i++) begin
            a_v0 = 1'b1; a_d0 = 20'hC0000 + 20'(i);
            step();
        end
        a_v0 = 1'b0;
        check("seq_pending", 32'(a_pending), 3);
        a_vblank = 1'b1;
        step();
        check("seq_open_no_wr", 32'(a_wr_en), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_wr_en", 32'(a_wr_en), 1);
            check("seq_data", 32'(a_wr_data), 32'h000C0000 + 32'(i));
            check("seq_src", 32'(a_wr_src), 0);
        end
        step();
        check("seq_idle", 32'(a_wr_en), 0);
        check("seq_hold_data", 32'(a_wr_data), 32'h000C0002);
        a_vblank = 1'b0;
        step();
        check("seq_close_defer", 32'(a_defer), 0);

        // Flush with a concurrent push while a write is in flight
        for (int i = 0; i < 2; i++) begin
            a_v0 = 1'b1; a_d0 = 20'hD0000 + 20'(i);
            step();
        end
        a_v0 = 1'b0;
        a_vblank = 1'b1;
        step();
        step();
        check("fl_inflight_en", 32'(a_wr_en), 1);
        check("fl_inflight_data", 32'(a_wr_data), 32'h000D0000);
        a_flush = 1'b1; a_v1 = 1'b1; a_d1 = 20'hBBAD0;
        step();
        a_flush = 1'b0; a_v1 = 1'b0;
        check("fl_no_wr", 32'(a_wr_en), 0);
        check("fl_pending", 32'(a_pending), 0);
        check("fl_state", 32'(dut_a.state), 32'(ST_OPEN));
        check("fl_budget", 32'(dut_a.budget), 1);
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_wr_en) writes++;
        end
        check("fl_later_writes", 32'(writes), 0);
        a_vblank = 1'b0;
        step();
        check("fl_close_defer", 32'(a_defer), 0);

        // Reset asserted mid-window drops the in-flight write immediately
        for (int i = 0; i < 3; i++) begin
            a_v0 = 1'b1; a_d0 = 20'hE0000 + 20'(i);
            step();
        end
        a_v0 = 1'b0;
        a_vblank = 1'b1;
        step();
        step();
        check("mid_wr_en", 32'(a_wr_en), 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(a_wr_en), 0);
        check("mid_rst_pending", 32'(a_pending), 0);
        check("mid_rst_ready0", 32'(a_r0), 0);
        check("mid_rst_data", 32'(a_wr_data), 0);

        // Release with the window already open: nothing written until the next rising edge
        #2;
        nrst = 1'b1;
        step();
        check("open_rel_ready0", 32'(a_r0), 1);
        for (int i = 0; i < 2; i++) begin
            a_v0 = 1'b1; a_d0 = 20'hF0000 + 20'(i);
            step();
        end
        a_v0 = 1'b0;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_wr_en) writes++;
        end
        check("open_rel_writes", 32'(writes), 0);
        check("open_rel_pending", 32'(a_pending), 2);
        a_vblank = 1'b0;
        step();
        check("open_rel_defer", 32'(a_defer), 0);
        a_vblank = 1'b1;
        step();
        check("reopen_no_wr", 32'(a_wr_en), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reopen_wr_en", 32'(a_wr_en), 1);
            check("reopen_data", 32'(a_wr_data), 32'h000F0000 + 32'(i));
        end
        step();
        check("reopen_idle", 32'(a_wr_en), 0);
        a_vblank = 1'b0;
        step();

        // Budget of two per window on the second instance
        for (int i = 0; i < 4; i++) begin
            b_v0 = 1'b1; b_d0 = 20'h30000 + 20'(i);
            step();
        end
        b_v0 = 1'b0;
        b_vblank = 1'b1;
        step();
        writes = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (b_wr_en) begin
                check("bud_data", 32'(b_wr_data), 32'h00030000 + 32'(writes));
                writes++;
            end
        end
        check("bud_writes", 32'(writes), 2);
        check("bud_state", 32'(dut_b.state), 32'(ST_EXHAUSTED));
        check("bud_pending", 32'(b_pending), 2);
        b_vblank = 1'b0;
        step();
        check("bud_defer_pulse", 32'(b_defer), 1);
        step();
        check("bud_defer_clear", 32'(b_defer), 0);
        b_vblank = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            check("bud_next_en", 32'(b_wr_en), 1);
            check("bud_next_data", 32'(b_wr_data), 32'h00030002 + 32'(i));
        end
        step();
        check("bud_next_idle", 32'(b_wr_en), 0);
        check("bud_next_pending", 32'(b_pending), 0);
        b_vblank = 1'b0;
        step();
        check("bud_close_defer", 32'(b_defer), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/osd_wr_arbiter.md
OSD_WR_ARBITER -- requirements
Module: osd_wr_arbiter

Interface
REQ-001 Parameter DW, default 20, SHALL set the write-word width as {ctrl,data}, matching the OSD write vector.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL set the entries per requester FIFO.
REQ-003 Parameter MAX_PER_WIN, default 64 (1..255), SHALL set the maximum writes issued per blanking window.
REQ-004 N64_CLK_i  in  1  SHALL be the sole clock; all logic is on its rising edge.
REQ-005 CTRL_nRST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 vblank_i  in  1  SHALL be the write-window-open level, synchronous to N64_CLK_i.
REQ-007 flush_i  in  1  SHALL be a single-cycle request to discard all queued words.
REQ-008 req0_valid_i / req0_data_i / req0_ready_o  in / in[DW] / out  SHALL form the CPU requester port, transferring when valid and ready are both 1.
REQ-009 req1_valid_i / req1_data_i / req1_ready_o  in / in[DW] / out  SHALL form the status-overlay requester port, with the same handshake.
REQ-010 wr_en_o  out  1  SHALL be the write strobe to OSD RAM.
REQ-011 wr_data_o  out  DW  SHALL be the write word, valid while wr_en_o=1.
REQ-012 wr_src_o  out  1  SHALL identify the requester of the current write.
REQ-013 pending_o  out  4  SHALL report the total queued entries in both FIFOs.
REQ-014 defer_o  out  1  SHALL pulse one cycle when a window closes with entries still queued.

Function
REQ-015 Each requester port SHALL have a private FIFO; a push occurs on the cycle valid and ready are both 1.
REQ-016 ready_o SHALL be registered and equal 1 exactly when the FIFO's next-cycle count is below FIFO_DEPTH.
REQ-017 A simultaneous push and pop on one FIFO SHALL leave its count unchanged, with data order preserved.
REQ-018 A full FIFO SHALL hold ready_o at 0 for the cycle, even if a pop occurs in that cycle.
REQ-019 The FSM SHALL have exactly three states: CLOSED (reset state), OPEN and EXHAUSTED.
REQ-020 CLOSED->OPEN SHALL occur only on a vblank_i rising edge (vblank_i=1 and registered vblank_q=0), clearing the budget counter.
REQ-021 In OPEN, with vblank_i=1 and at least one FIFO non-empty, exactly one word SHALL be popped per cycle and the budget counter incremented.
REQ-022 Arbitration SHALL be round-robin: if both FIFOs are non-empty, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-023 A popped word SHALL appear on wr_data_o/wr_src_o with wr_en_o=1 exactly one cycle after the pop; otherwise wr_en_o=0 and data/src hold their last values.
REQ-024 When the budget counter reaches MAX_PER_WIN, OPEN->EXHAUSTED SHALL occur and no further pops SHALL happen in that window.
REQ-025 OPEN or EXHAUSTED SHALL go to CLOSED in any cycle with vblank_i=0, with no pop in that cycle.
REQ-026 On that transition to CLOSED, defer_o SHALL pulse for one cycle if pending_o != 0 after that cycle's pushes.
REQ-027 flush_i SHALL empty both FIFOs at the next edge, and a push in the same cycle SHALL be discarded.
REQ-028 A word popped before flush_i SHALL still be written.
REQ-029 flush_i SHALL not change the FSM state or the budget counter.
REQ-030 pending_o SHALL be registered and saturate at 15.

Reset
REQ-031 Asserting CTRL_nRST SHALL immediately force: state CLOSED; FIFOs empty; vblank_q=1; budget 0; last-served pointer 1.
REQ-032 Asserting CTRL_nRST SHALL immediately force all outputs to 0, including req0_ready_o and req1_ready_o.
REQ-033 Both ready_o outputs SHALL rise at the first clock edge after reset release.
REQ-034 A window already open at reset release SHALL NOT be used; writing starts only at the next vblank_i rising edge.
REQ-035 A reset asserted mid-window SHALL drop all queued and in-flight words without a write strobe.

Structure
REQ-036 State encodings and the DW/FIFO_DEPTH/MAX_PER_WIN defaults SHALL reside in the shared config header.
REQ-037 The per-requester queue SHALL be one sub-module, osd_wr_fifo, instantiated twice.

Verification
REQ-038 Push 3 words to req0 with vblank_i=0, then raise vblank_i -> 3 consecutive wr_en_o pulses, the first one cycle after the first pop, in order, with wr_src_o=0.
REQ-039 Fill both FIFOs (4+4), then open the window -> writes alternate src 0,1,0,1,... for 8 cycles, and pending_o counts 8->0.
REQ-040 Set MAX_PER_WIN=2 with 4 words queued and hold the window open 10 cycles -> exactly 2 writes, state EXHAUSTED; on close, defer_o pulses once; on the next window the remaining 2 are written.
REQ-041 Push a 5th word to a full req0 -> req0_ready_o=0 and no transfer occurs; the FIFO contents are unchanged.
REQ-042 Release reset with vblank_i=1 and words queued -> no writes until vblank_i falls and then rises again.
REQ-043 Assert flush_i with a concurrent push while OPEN -> the pop already in flight is written; afterwards pending_o=0 and the pushed word is never written.
